reaction_timer_core: RTL
========================

# reaction_timer_core

Reaction-timer control block fed by the 1 kHz divided clock from the clock-divider stage. It edge-detects that square wave into a one-cycle millisecond tick and runs the round sequence: wait a pseudo-random delay, light the stimulus LED, then count milliseconds until the player reacts. It flags false starts and timeouts, and holds the result in binary milliseconds for the display stage downstream.

## Interface
- MIN_DELAY_MS, 1000: fixed part of the pre-stimulus delay, in ms (≥1).
- RAND_BITS, 11: width of the random delay add-on; add-on range 0..2^RAND_BITS−1 ms.
- MAX_MS, 9999: reaction count ceiling; reaching it ends the round as a timeout.
- clk  input  1  100 MHz system clock.
- reset  input  1  synchronous, active-high; clock clk.
- ms_clk  input  1  divided 1 kHz square wave, synchronous to clk; each rising edge is one ms.
- start_btn  input  1  start/restart button, already debounced and synchronous.
- react_btn  input  1  reaction button, already debounced and synchronous.
- led  output  1  stimulus LED, high only in ARMED.
- result_ms  output  14  latched reaction time in ms.
- result_valid  output  1  high in DONE.
- false_start  output  1  high in FAULT.
- timeout  output  1  high in DONE when the round ended at MAX_MS.
- busy  output  1  high in WAIT or ARMED.

## Operation
- Edge detect: tick = ms_clk & ~ms_clk_q. start_e and react_e are formed the same way. ms_clk_q resets to 0. The two button _q registers reset to 1, so a button held through reset produces no edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset, advances every clk cycle. It never reaches all-zero.
- States: IDLE, WAIT, ARMED, DONE, FAULT. Encoding is free.
- IDLE: on start_e, go to WAIT. Load delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS−1:0], using the LFSR value in that cycle. Clear ms_cnt.
- WAIT:
  - react_e goes to FAULT. This has priority over tick.
  - Otherwise, on tick: if delay_cnt == 1, go to ARMED with ms_cnt = 0; else decrement delay_cnt.
  - start_e is ignored.
- ARMED:
  - react_e goes to DONE with result_ms = ms_cnt, using the pre-increment value if tick occurs in the same cycle, and timeout = 0.
  - Otherwise, on tick: if ms_cnt + 1 == MAX_MS, go to DONE with result_ms = MAX_MS and timeout = 1; else increment ms_cnt.
  - start_e is ignored.
- DONE / FAULT: outputs hold. start_e starts a new round exactly as from IDLE and clears result_valid, timeout and false_start. result_ms holds its old value until the next DONE.
- Widths: delay_cnt 16 bits, with MIN_DELAY_MS + 2^RAND_BITS − 1 ≤ 65535. ms_cnt and result_ms are 14 bits, with MAX_MS ≤ 16383.

## Timing
- Reset values: state IDLE; led, result_valid, false_start, timeout, busy = 0; result_ms = 0; counters = 0.
- All outputs are registered or decoded from registered state. Latency from an input's first high-sampled clk edge to the output change is 1 clk.
- Stimulus: led rises on the clk edge that samples the D-th tick after WAIT entry, where D is the loaded delay.
- Reaction time: result_ms equals the number of ticks sampled in ARMED before the react_e cycle.
- Reset asserted mid-round: on the next clk edge the block goes to IDLE with all outputs at reset values. No partial result is kept.
- ms_clk held static: the block freezes in WAIT or ARMED and stays there indefinitely.

## Test plan
Sim parameters: MIN_DELAY_MS=3, RAND_BITS=2, MAX_MS=20. Drive ms_clk with period 10 clk.
- Normal round: start pulse, then react 5 ticks after led rises. Required: led high in [3,6] ticks after start; then result_valid=1, result_ms=5, timeout=0, led=0, busy=0.
- False start: react pulse 1 tick after start. Required: false_start=1, led never rises, result_ms unchanged.
- Timeout: start, never react. Required: after 20 ticks in ARMED, result_valid=1, timeout=1, result_ms=20.
- Simultaneity: react_e in the same cycle as the 4th ARMED tick. Required: result_ms=3. Start pressed during WAIT/ARMED has no effect.
- Reset mid-ARMED, with start_btn held high through reset. Required: all outputs 0 the next cycle, state IDLE, and no round starts until start_btn falls and rises again.
- Restart from DONE: start pulse. Required: result_valid, timeout and false_start clear next cycle, busy=1, and the new delay is in [3,6].

Source files
------------

// File: rtl/reaction_timer_core.sv
// reaction_timer_core: ms-tick edge detect, random delay, stimulus LED and reaction timing
module reaction_timer_core #(
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_clk,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic        led,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, WAIT, ARMED, DONE, FAULT} state_t;
    state_t state, state_n;
    logic ms_clk_q, start_q, react_q;
    logic [15:0] lfsr, delay_cnt, delay_n;
    logic [13:0] ms_cnt, ms_n, result_n;
    logic timeout_q, timeout_n;
    logic tick, start_e, react_e;
    logic [15:0] delay_load;
    assign tick       = ms_clk & ~ms_clk_q;
    assign start_e    = start_btn & ~start_q;
    assign react_e    = react_btn & ~react_q;
    assign delay_load = 16'(MIN_DELAY_MS) + 16'(lfsr[RAND_BITS-1:0]);
    assign led          = state == ARMED;
    assign busy         = state == WAIT || state == ARMED;
    assign result_valid = state == DONE;
    assign false_start  = state == FAULT;
    assign timeout      = timeout_q;
    // input edge history (buttons reset high so a held button gives no edge) and free-running LFSR
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_clk_q <= 1'b0;
            start_q  <= 1'b1;
            react_q  <= 1'b1;
            lfsr     <= 16'hACE1;
        end else begin
            ms_clk_q <= ms_clk;
            start_q  <= start_btn;
            react_q  <= react_btn;
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
    // round state and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            delay_cnt <= '0;
            ms_cnt    <= '0;
            result_ms <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            delay_cnt <= delay_n;
            ms_cnt    <= ms_n;
            result_ms <= result_n;
            timeout_q <= timeout_n;
        end
    end
    // next-state: react beats tick in WAIT/ARMED; start is only honoured outside a round
    always_comb begin
        state_n   = state;
        delay_n   = delay_cnt;
        ms_n      = ms_cnt;
        result_n  = result_ms;
        timeout_n = timeout_q;
        case (state)
            IDLE, DONE, FAULT: begin
                if (start_e) begin
                    state_n   = WAIT;
                    delay_n   = delay_load;
                    ms_n      = '0;
                    timeout_n = 1'b0;
                end
            end
            WAIT: begin
                if (react_e) begin
                    state_n = FAULT;
                end else if (tick) begin
                    if (delay_cnt == 16'd1) begin
                        state_n = ARMED;
                        ms_n    = '0;
                    end else begin
                        delay_n = delay_cnt - 16'd1;
                    end
                end
            end
            ARMED: begin
                if (react_e) begin
                    state_n   = DONE;
                    result_n  = ms_cnt;
                    timeout_n = 1'b0;
                end else if (tick) begin
                    if (ms_cnt + 14'd1 == 14'(MAX_MS)) begin
                        state_n   = DONE;
                        result_n  = 14'(MAX_MS);
                        timeout_n = 1'b1;
                    end else begin
                        ms_n = ms_cnt + 14'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
